// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared cache types: MSI state, frame layout, controller states
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    localparam int DC_SETS = 16;
    localparam int DC_IDXW = $clog2(DC_SETS);
    localparam int DTAG_W  = 32 - DC_IDXW - 2;

    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        M = 2'd2
    } msi_t;

    typedef struct packed {
        msi_t              st;
        logic [DTAG_W-1:0] tag;
        word_t             data;
    } dcache_frame_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        FETCH   = 3'd2,
        SNOOP   = 3'd3,
        FLUSH   = 3'd4,
        FLUSHED = 3'd5
    } dstate_t;
endpackage

// File: rtl/coherent_dcache_frames.sv
// rtl/coherent_dcache_frames.sv - dcache_frames: frame register array, core and snoop read ports
module dcache_frames
    import cpu_types_pkg::*;
#(
    parameter int SETS = DC_SETS,
    parameter int IDXW = $clog2(SETS)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [IDXW-1:0] cidx,
    input  logic [IDXW-1:0] sidx,
    input  logic            wen,
    input  logic [IDXW-1:0] widx,
    input  dcache_frame_t   wframe,
    output dcache_frame_t   cframe,
    output dcache_frame_t   sframe
);
    dcache_frame_t frames [SETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                frames[i] <= '0;
            end
        end else if (wen) begin
            frames[widx] <= wframe;
        end
    end

    assign cframe = frames[cidx];
    assign sframe = frames[sidx];
endmodule

// File: rtl/coherent_dcache.sv
// rtl/coherent_dcache.sv - direct-mapped write-back L1 dcache with MSI snooping and halt flush
module coherent_dcache
    import cpu_types_pkg::*;
#(
    parameter int SETS = DC_SETS,
    parameter int IDXW = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait,
    output logic        cctrans,
    output logic        ccwrite,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr
);
    dstate_t state, next_state, ret_state, next_ret;
    logic [IDXW-1:0] fidx, next_fidx;
    logic [IDXW-1:0] cidx, ridx, sidx, widx;
    logic [DTAG_W-1:0] ctag, stag;
    dcache_frame_t cf, sf, wframe;
    logic fwen;
    logic req, tag_eq, rd_hit, wr_hit, hit, victim_dirty, snoop_go, s_match;
    logic unused_bits;

    assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[1:0]};

    assign req  = dmemREN | dmemWEN;
    assign cidx = dmemaddr[IDXW+1:2];
    assign ctag = dmemaddr[31:IDXW+2];
    assign sidx = ccsnoopaddr[IDXW+1:2];
    assign stag = ccsnoopaddr[31:IDXW+2];
    // The flush walk borrows the core read port.
    assign ridx = (state == FLUSH) ? fidx : cidx;

    dcache_frames #(.SETS(SETS), .IDXW(IDXW)) u_frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .cidx   (ridx),
        .sidx   (sidx),
        .wen    (fwen),
        .widx   (widx),
        .wframe (wframe),
        .cframe (cf),
        .sframe (sf)
    );

    assign tag_eq       = (cf.tag == ctag);
    assign rd_hit       = tag_eq && (cf.st == S || cf.st == M);
    assign wr_hit       = tag_eq && (cf.st == M);
    assign hit          = dmemWEN ? wr_hit : (dmemREN & rd_hit);
    assign victim_dirty = (cf.st == M) && !tag_eq;
    assign snoop_go     = ccwait && (state != FLUSHED) && (state != SNOOP);
    assign s_match      = (sf.st != I) && (sf.tag == stag);
    assign dmemload     = cf.data;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ret_state <= IDLE;
            fidx      <= '0;
        end else begin
            state     <= next_state;
            ret_state <= next_ret;
            fidx      <= next_fidx;
        end
    end

    always_comb begin
        next_state = state;
        next_ret   = ret_state;
        next_fidx  = fidx;
        dhit       = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        cctrans    = 1'b0;
        ccwrite    = 1'b0;
        flushed    = 1'b0;
        fwen       = 1'b0;
        widx       = ridx;
        wframe     = cf;
        if (snoop_go) begin
            // A suspended miss restarts from IDLE so hit/miss is re-evaluated after the snoop.
            next_state = SNOOP;
            next_ret   = (state == FLUSH) ? FLUSH : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        next_state = FLUSH;
                        next_fidx  = '0;
                    end else if (req) begin
                        if (hit) begin
                            dhit = 1'b1;
                            if (dmemWEN) begin
                                fwen        = 1'b1;
                                wframe.st   = M;
                                wframe.data = dmemstore;
                            end
                        end else if (victim_dirty) begin
                            next_state = WB;
                        end else begin
                            next_state = FETCH;
                        end
                    end
                end
                WB: begin
                    dWEN   = 1'b1;
                    daddr  = {cf.tag, cidx, 2'b00};
                    dstore = cf.data;
                    if (!dwait) begin
                        fwen       = 1'b1;
                        wframe.st  = I;
                        next_state = FETCH;
                    end
                end
                FETCH: begin
                    dREN    = 1'b1;
                    cctrans = 1'b1;
                    ccwrite = dmemWEN;
                    daddr   = dmemaddr;
                    if (!dwait) begin
                        fwen        = 1'b1;
                        wframe.st   = dmemWEN ? M : S;
                        wframe.tag  = ctag;
                        wframe.data = dload;
                        next_state  = IDLE;
                    end
                end
                SNOOP: begin
                    if (!ccwait) begin
                        next_state = ret_state;
                    end else if (s_match) begin
                        widx   = sidx;
                        wframe = sf;
                        if (sf.st == M) begin
                            dWEN   = 1'b1;
                            daddr  = ccsnoopaddr;
                            dstore = sf.data;
                            if (!dwait) begin
                                fwen      = 1'b1;
                                wframe.st = ccinv ? I : S;
                            end
                        end else if (ccinv) begin
                            fwen      = 1'b1;
                            wframe.st = I;
                        end
                    end
                end
                FLUSH: begin
                    if (cf.st == M) begin
                        dWEN   = 1'b1;
                        daddr  = {cf.tag, fidx, 2'b00};
                        dstore = cf.data;
                    end
                    if (cf.st != M || !dwait) begin
                        fwen      = 1'b1;
                        wframe.st = I;
                        next_fidx = fidx + 1'b1;
                        if (fidx == IDXW'(SETS - 1)) begin
                            next_state = FLUSHED;
                        end
                    end
                end
                FLUSHED: begin
                    flushed = 1'b1;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coherent_dcache.sv
// tb/tb_coherent_dcache.sv - scoreboard bench for coherent_dcache: directed core, bus and snoop vectors
module tb_coherent_dcache;
    logic        CLK, nRST;
    logic        dmemREN, dmemWEN, dhit, halt, flushed;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic        dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
    logic [31:0] daddr, dstore, dload, ccsnoopaddr;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ccw;
    } bus_t;
    typedef struct {
        logic        wr;
        logic [31:0] data;
    } hit_t;

    bus_t exp_bus [$];
    hit_t exp_hit [$];
    logic [31:0] mem [logic [31:0]];
    int vectors = 0;
    int miscompares = 0;
    int resp_cnt = 0;
    localparam int LAT = 3;

    coherent_dcache dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmemload(dmemload), .dhit(dhit), .halt(halt), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_rd(input logic [31:0] addr, input logic ccw);
        bus_t b;
        b.wr = 1'b0; b.addr = addr; b.data = '0; b.ccw = ccw;
        exp_bus.push_back(b);
    endfunction

    function automatic void push_wr(input logic [31:0] addr, input logic [31:0] data);
        bus_t b;
        b.wr = 1'b1; b.addr = addr; b.data = data; b.ccw = 1'b0;
        exp_bus.push_back(b);
    endfunction

    // Memory/bus responder: LAT stalled cycles, then one completing cycle.
    initial begin
        dwait = 1'b1;
        dload = '0;
        forever begin
            @(posedge CLK); #2;
            if (dREN || dWEN) begin
                dload = mem.exists(daddr) ? mem[daddr] : 32'h0;
                if (resp_cnt == LAT) begin
                    dwait = 1'b0;
                    resp_cnt = 0;
                    if (dWEN) mem[daddr] = dstore;
                end else begin
                    dwait = 1'b1;
                    resp_cnt++;
                end
            end else begin
                dwait = 1'b1;
                resp_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a hit or a bus transfer.
    initial begin
        forever begin
            @(negedge CLK);
            if (nRST) begin
                if (dhit) begin
                    if (exp_hit.size() == 0) begin
                        chk("unexpected_dhit", 32'(dhit), 32'h0);
                    end else begin
                        hit_t h;
                        h = exp_hit.pop_front();
                        chk("hit_kind_wen", 32'(dmemWEN), 32'(h.wr));
                        if (!h.wr) chk("dmemload", dmemload, h.data);
                    end
                end
                if ((dREN || dWEN) && !dwait) begin
                    if (exp_bus.size() == 0) begin
                        chk("unexpected_bus_addr", daddr, 32'hFFFF_FFFF);
                    end else begin
                        bus_t b;
                        b = exp_bus.pop_front();
                        chk("bus_dwen", 32'(dWEN), 32'(b.wr));
                        chk("bus_daddr", daddr, b.addr);
                        chk("bus_cctrans", 32'(cctrans), 32'(!b.wr));
                        if (b.wr) chk("bus_dstore", dstore, b.data);
                        else      chk("bus_ccwrite", 32'(ccwrite), 32'(b.ccw));
                    end
                end
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_load);
        hit_t h;
        logic got;
        h.wr = wr; h.data = exp_load;
        exp_hit.push_back(h);
        @(posedge CLK); #1;
        dmemaddr = addr; dmemstore = data; dmemWEN = wr; dmemREN = !wr;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge CLK);
            if (dhit) got = 1'b1;
        end
        chk("access_completes", 32'(got), 32'h1);
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] addr, input logic inv, input int n);
        @(posedge CLK); #1;
        ccwait = 1'b1; ccsnoopaddr = addr; ccinv = inv;
        repeat (n) @(posedge CLK);
        #1 ccwait = 1'b0; ccinv = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
        halt = 1'b0; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = '0;
        mem[32'h40] = 32'hDEADBEEF;
        mem[32'h44] = 32'h11112222;
        repeat (2) @(negedge CLK);
        chk("rst_dREN", 32'(dREN), 32'h0);
        chk("rst_dWEN", 32'(dWEN), 32'h0);
        chk("rst_dhit", 32'(dhit), 32'h0);
        chk("rst_flushed", 32'(flushed), 32'h0);
        chk("rst_cctrans", 32'(cctrans), 32'h0);
        chk("rst_dmemload", dmemload, 32'h0);
        nRST = 1'b1;

        // Cold read, then store upgrade from S, then hit with no bus traffic.
        push_rd(32'h40, 1'b0);
        access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        push_rd(32'h40, 1'b1);
        access(1'b1, 32'h40, 32'h12345678, 32'h0);
        access(1'b0, 32'h40, 32'h0, 32'h12345678);

        // Conflict miss on dirty victim: writeback of 0x40 then read-exclusive of 0x80.
        push_wr(32'h40, 32'h12345678);
        push_rd(32'h80, 1'b1);
        access(1'b1, 32'h80, 32'hA5A5A5A5, 32'h0);

        // Non-invalidating snoop on M: supply data, drop to S.
        push_wr(32'h80, 32'hA5A5A5A5);
        snoop(32'h80, 1'b0, 8);
        access(1'b0, 32'h80, 32'h0, 32'hA5A5A5A5);
        push_rd(32'h80, 1'b1);
        access(1'b1, 32'h80, 32'h5A5A5A5A, 32'h0);

        // Invalidating snoop on M, on S, and a snoop miss.
        push_wr(32'h80, 32'h5A5A5A5A);
        snoop(32'h80, 1'b1, 8);
        push_rd(32'h80, 1'b0);
        access(1'b0, 32'h80, 32'h0, 32'h5A5A5A5A);
        snoop(32'h80, 1'b1, 4);
        push_rd(32'h80, 1'b0);
        access(1'b0, 32'h80, 32'h0, 32'h5A5A5A5A);
        snoop(32'h3C0, 1'b1, 4);
        access(1'b0, 32'h80, 32'h0, 32'h5A5A5A5A);

        // Snoop arriving while own fetch is pending.
        push_rd(32'h44, 1'b0);
        fork
            access(1'b0, 32'h44, 32'h0, 32'h11112222);
            begin
                repeat (2) @(posedge CLK);
                @(negedge CLK);
                chk("fetch_pending_dREN", 32'(dREN), 32'h1);
                @(posedge CLK); #1;
                ccwait = 1'b1; ccsnoopaddr = 32'h3C0; ccinv = 1'b0;
                @(negedge CLK);
                chk("snoop_suspends_dREN", 32'(dREN), 32'h0);
                repeat (4) @(posedge CLK);
                #1 ccwait = 1'b0;
            end
        join

        // Dirty frames 2 and 9, then halt flush.
        push_rd(32'h08, 1'b1);
        access(1'b1, 32'h08, 32'hB0B0B0B0, 32'h0);
        push_rd(32'h24, 1'b1);
        access(1'b1, 32'h24, 32'h90909090, 32'h0);
        push_wr(32'h08, 32'hB0B0B0B0);
        push_wr(32'h24, 32'h90909090);
        @(posedge CLK); #1 halt = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge CLK);
            if (flushed) got = 1'b1;
        end
        chk("flush_completes", 32'(got), 32'h1);
        repeat (5) @(negedge CLK);
        chk("flushed_held", 32'(flushed), 32'h1);
        @(posedge CLK); #1;
        ccwait = 1'b1; ccsnoopaddr = 32'h24; ccinv = 1'b1;
        repeat (2) @(negedge CLK);
        chk("flushed_snoop_dWEN", 32'(dWEN), 32'h0);
        chk("flushed_snoop_flushed", 32'(flushed), 32'h1);
        ccwait = 1'b0;
        repeat (3) @(negedge CLK);

        chk("bus_queue_drained", 32'(exp_bus.size()), 32'h0);
        chk("hit_queue_drained", 32'(exp_hit.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
